// File: rtl/ifetch_unit.sv
// Instruction fetch: issues one req/gnt/rvalid bus transaction per PC and buffers the instruction
// for decode. Responses made stale by a redirect are dropped.
module ifetch_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ILEN = 32
) (
   input  logic            clk,
   input  logic            n_reset,
   input  logic [XLEN-1:0] fetch_pc,
   input  logic            redirect,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   input  logic            imem_err,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            fetch_fault,
   output logic            pc_advance
);

   typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

   state_e            state_q, state_d;
   logic              drop_q;
   logic [XLEN-1:0]   req_pc_q;
   logic [ILEN-1:0]   instr_q;
   logic [XLEN-1:0]   instr_pc_q;
   logic              fault_q;
   logic              misaligned;

   assign misaligned = (fetch_pc[1:0] != 2'b00);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= StReq;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StReq: begin
            if (misaligned) begin
               state_d = StHold;
            end else if (imem_gnt) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (imem_rvalid) begin
               state_d = (drop_q || redirect) ? StReq : StHold;
            end
         end
         StHold: begin
            // A completing handshake and a redirect both leave HOLD; the handshake still counts.
            if (instr_ready || redirect) begin
               state_d = StReq;
            end
         end
         default: state_d = StReq;
      endcase
   end

   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      pc_advance  = 1'b0;
      unique case (state_q)
         StReq: imem_req = n_reset && !misaligned;
         StHold: begin
            instr_valid = 1'b1;
            pc_advance  = instr_ready;
         end
         default: ;
      endcase
   end

   assign imem_addr = fetch_pc;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         drop_q     <= 1'b0;
         req_pc_q   <= '0;
         instr_q    <= '0;
         instr_pc_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         case (state_q)
            StReq: begin
               if (misaligned) begin
                  instr_q    <= '0;
                  instr_pc_q <= fetch_pc;
                  fault_q    <= 1'b1;
               end else if (imem_gnt) begin
                  req_pc_q <= fetch_pc;
                  drop_q   <= redirect;
               end
            end
            StWait: begin
               if (imem_rvalid) begin
                  drop_q <= 1'b0;
                  if (!(drop_q || redirect)) begin
                     instr_q    <= imem_rdata;
                     instr_pc_q <= req_pc_q;
                     fault_q    <= imem_err;
                  end
               end else if (redirect) begin
                  drop_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run against a PC/memory model.
module tb_ifetch_unit;

   logic        clk;
   logic        n_reset;
   logic [31:0] fetch_pc;
   logic        redirect;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        fetch_fault;
   logic        pc_advance;

   int n_assert = 0;
   int n_fail   = 0;

   ifetch_unit #(.XLEN(32), .ILEN(32)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .fetch_pc    (fetch_pc),
      .redirect    (redirect),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .imem_err    (imem_err),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .fetch_fault (fetch_fault),
      .pc_advance  (pc_advance)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want test completion");
      $fatal(1, "watchdog expired");
   end

   // Memory image and error map seen by the random run.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return (a[6:2] == 5'h13);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      imem_err    = 1'b0;
      redirect    = 1'b0;
      instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_reset  = 1'b0;
      fetch_pc = 32'h0;
      idle();
      instr_ready = 1'b1;
      #3;
      n_assert++;
      if ({imem_req, instr_valid, fetch_fault, pc_advance} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000",
                  {imem_req, instr_valid, fetch_fault, pc_advance});
      end
      n_assert++;
      if ({instr, instr_pc} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0", {instr, instr_pc});
      end
      tick();
      tick();
      n_reset = 1'b1;
      instr_ready = 1'b0;
   endtask

   task automatic test_zero_wait();
      tick();
      fetch_pc = 32'h0;
      imem_gnt = 1'b1;
      #1;
      n_assert++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL zw_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h0});
      end
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      #1;
      n_assert++;
      if ({imem_req, instr_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL zw_wait: got %b want 00", {imem_req, instr_valid});
      end
      tick();
      imem_rvalid = 1'b0;
      instr_ready = 1'b1;
      #1;
      n_assert++;
      if ({instr_valid, instr, instr_pc, fetch_fault, pc_advance} !==
          {1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL zw_handoff: got %h want %h",
                  {instr_valid, instr, instr_pc, fetch_fault, pc_advance},
                  {1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b1});
      end
      tick();
      fetch_pc = 32'h4;
      #1;
      n_assert++;
      if ({imem_req, imem_addr, instr_valid, pc_advance} !== {1'b1, 32'h4, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL zw_next_req: got %h want %h",
                  {imem_req, imem_addr, instr_valid, pc_advance}, {1'b1, 32'h4, 1'b0, 1'b0});
      end
      idle();
   endtask

   task automatic test_wait_states();
      int adv_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         fetch_pc    = 32'h100;
         imem_gnt    = (c == 3);
         imem_rvalid = (c == 5);
         imem_rdata  = (c == 5) ? 32'h1234_5678 : 32'hFFFF_FFFF;
         instr_ready = (c >= 6);
         #1;
         adv_cnt += int'(pc_advance);
         if (c <= 3) begin
            n_assert++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
               n_fail++;
               $display("FAIL ws_req_hold c%0d: got %h want %h", c, {imem_req, imem_addr},
                        {1'b1, 32'h100});
            end
         end
         if (c == 6) begin
            n_assert++;
            if ({instr_valid, instr, instr_pc, fetch_fault} !==
                {1'b1, 32'h1234_5678, 32'h100, 1'b0}) begin
               n_fail++;
               $display("FAIL ws_handoff: got %h want %h",
                        {instr_valid, instr, instr_pc, fetch_fault},
                        {1'b1, 32'h1234_5678, 32'h100, 1'b0});
            end
         end
      end
      n_assert++;
      if (adv_cnt != 1) begin
         n_fail++;
         $display("FAIL ws_advance_count: got %0d want 1", adv_cnt);
      end
      idle();
   endtask

   task automatic test_redirect_wait();
      tick();
      fetch_pc = 32'h10;
      imem_gnt = 1'b1;
      #1;
      n_assert++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
         n_fail++;
         $display("FAIL rw_req: got %h want %h", {imem_req, imem_addr}, {1'b1, 32'h10});
      end
      tick();
      imem_gnt = 1'b0;
      redirect = 1'b1;
      tick();
      redirect    = 1'b0;
      fetch_pc    = 32'h40;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      instr_ready = 1'b1;
      #1;
      n_assert++;
      if ({instr_valid, pc_advance} !== 2'b00) begin
         n_fail++;
         $display("FAIL rw_stale: got %b want 00", {instr_valid, pc_advance});
      end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_assert++;
      if ({imem_req, imem_addr, instr_valid, pc_advance} !== {1'b1, 32'h40, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rw_new_req: got %h want %h", {imem_req, imem_addr, instr_valid, pc_advance},
                  {1'b1, 32'h40, 1'b0, 1'b0});
      end
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h00A0_0113;
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_assert++;
      if ({instr_valid, instr, instr_pc, fetch_fault, pc_advance} !==
          {1'b1, 32'h00A0_0113, 32'h40, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL rw_handoff: got %h want %h",
                  {instr_valid, instr, instr_pc, fetch_fault, pc_advance},
                  {1'b1, 32'h00A0_0113, 32'h40, 1'b0, 1'b1});
      end
      tick();
      idle();
   endtask

   task automatic test_redirect_same_cycle();
      tick();
      fetch_pc    = 32'h80;
      imem_gnt    = 1'b1;
      instr_ready = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      redirect    = 1'b1;
      tick();
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      fetch_pc    = 32'hC0;
      #1;
      n_assert++;
      if ({instr_valid, pc_advance, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'hC0}) begin
         n_fail++;
         $display("FAIL rs_rvalid_redirect: got %h want %h",
                  {instr_valid, pc_advance, imem_req, imem_addr}, {1'b0, 1'b0, 1'b1, 32'hC0});
      end
      imem_gnt = 1'b1;
      redirect = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      redirect    = 1'b0;
      fetch_pc    = 32'h100;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD1_BAD1;
      #1;
      n_assert++;
      if ({instr_valid, pc_advance} !== 2'b00) begin
         n_fail++;
         $display("FAIL rs_gnt_redirect_stale: got %b want 00", {instr_valid, pc_advance});
      end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_assert++;
      if ({instr_valid, pc_advance, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 32'h100}) begin
         n_fail++;
         $display("FAIL rs_gnt_redirect_next: got %h want %h",
                  {instr_valid, pc_advance, imem_req, imem_addr}, {1'b0, 1'b0, 1'b1, 32'h100});
      end
      idle();
   endtask

   task automatic test_faults();
      tick();
      fetch_pc = 32'h6;
      #1;
      n_assert++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL ft_misaligned_req: got %b want 0", imem_req);
      end
      tick();
      instr_ready = 1'b1;
      #1;
      n_assert++;
      if ({instr_valid, instr, instr_pc, fetch_fault, pc_advance, imem_req} !==
          {1'b1, 32'h0, 32'h6, 1'b1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL ft_misaligned: got %h want %h",
                  {instr_valid, instr, instr_pc, fetch_fault, pc_advance, imem_req},
                  {1'b1, 32'h0, 32'h6, 1'b1, 1'b1, 1'b0});
      end
      tick();
      instr_ready = 1'b0;
      fetch_pc    = 32'h20;
      imem_gnt    = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_err    = 1'b1;
      imem_rdata  = 32'h1111_1111;
      tick();
      imem_rvalid = 1'b0;
      imem_err    = 1'b0;
      instr_ready = 1'b1;
      #1;
      n_assert++;
      if ({instr_valid, instr, instr_pc, fetch_fault, pc_advance} !==
          {1'b1, 32'h1111_1111, 32'h20, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL ft_bus_err: got %h want %h",
                  {instr_valid, instr, instr_pc, fetch_fault, pc_advance},
                  {1'b1, 32'h1111_1111, 32'h20, 1'b1, 1'b1});
      end
      tick();
      idle();
   endtask

   task automatic test_backpressure();
      tick();
      fetch_pc = 32'h200;
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hCAFE_0013;
      for (int c = 0; c < 5; c++) begin
         tick();
         // Spurious bus activity while holding must be ignored.
         fetch_pc    = 32'h204;
         imem_gnt    = 1'b1;
         imem_rvalid = 1'b1;
         imem_rdata  = 32'h7777_0000 + 32'(c);
         instr_ready = 1'b0;
         #1;
         n_assert++;
         if ({instr_valid, instr, instr_pc, fetch_fault, imem_req, pc_advance} !==
             {1'b1, 32'hCAFE_0013, 32'h200, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold c%0d: got %h want %h", c,
                     {instr_valid, instr, instr_pc, fetch_fault, imem_req, pc_advance},
                     {1'b1, 32'hCAFE_0013, 32'h200, 1'b0, 1'b0, 1'b0});
         end
      end
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      instr_ready = 1'b1;
      #1;
      n_assert++;
      if ({instr_valid, instr_pc, pc_advance} !== {1'b1, 32'h200, 1'b1}) begin
         n_fail++;
         $display("FAIL bp_release: got %h want %h", {instr_valid, instr_pc, pc_advance},
                  {1'b1, 32'h200, 1'b1});
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid_wait();
      tick();
      fetch_pc = 32'h300;
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      instr_ready = 1'b1;
      #1;
      n_reset  = 1'b0;
      fetch_pc = 32'h0;
      #1;
      n_assert++;
      if ({imem_req, instr_valid, instr, instr_pc, fetch_fault, pc_advance} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %h want 0",
                  {imem_req, instr_valid, instr, instr_pc, fetch_fault, pc_advance});
      end
      tick();
      n_reset     = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBADB_AD00;
      #1;
      n_assert++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_late_rvalid: got %h want %h", {imem_req, imem_addr, instr_valid},
                  {1'b1, 32'h0, 1'b0});
      end
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_assert++;
      if ({instr_valid, pc_advance} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_no_handoff: got %b want 00", {instr_valid, pc_advance});
      end
      imem_gnt = 1'b1;
      tick();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0013;
      tick();
      imem_rvalid = 1'b0;
      #1;
      n_assert++;
      if ({instr_valid, instr, instr_pc, pc_advance} !== {1'b1, 32'h0000_0013, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL rst_restart: got %h want %h", {instr_valid, instr, instr_pc, pc_advance},
                  {1'b1, 32'h0000_0013, 32'h0, 1'b1});
      end
      tick();
      idle();
   endtask

   // PC-unit and memory model: every hand-off must carry the architectural PC current at
   // that moment together with that address's memory word; stale fetches must never appear.
   task automatic test_random();
      logic [31:0] pc      = 32'h1000;
      logic [31:0] tgt     = '0;
      logic [31:0] paddr   = '0;
      logic        pending = 1'b0;
      logic        adv     = 1'b0;
      logic        redir   = 1'b0;
      int          dly     = 0;
      int          handoffs = 0;
      int          n_redir  = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (adv) pc = pc + 32'd4;
         if (redir) pc = tgt;
         adv   = 1'b0;
         redir = 1'b0;
         idle();
         fetch_pc    = pc;
         imem_rdata  = $urandom;
         instr_ready = ($urandom_range(0, 3) != 0);
         if (pending) begin
            if (dly == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(paddr);
               imem_err    = err_of(paddr);
               pending     = 1'b0;
            end else begin
               dly--;
            end
         end
         #1;
         if (imem_req) begin
            n_assert++;
            if (imem_addr !== pc) begin
               n_fail++;
               $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, imem_addr, pc);
            end
            if (!pending && !imem_rvalid && $urandom_range(0, 2) == 0) begin
               imem_gnt = 1'b1;
               pending  = 1'b1;
               paddr    = pc;
               dly      = $urandom_range(0, 2);
            end
         end
         if (!(instr_valid && instr_ready) && $urandom_range(0, 9) == 0) begin
            redirect = 1'b1;
            redir    = 1'b1;
            n_redir++;
            tgt      = (n_redir % 7 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         end
         #1;
         n_assert++;
         if (pc_advance !== (instr_valid && instr_ready)) begin
            n_fail++;
            $display("FAIL rnd_pc_advance cyc%0d: got %b want %b", cyc, pc_advance,
                     instr_valid && instr_ready);
         end
         if (instr_valid && instr_ready) begin
            handoffs++;
            adv = 1'b1;
            n_assert++;
            if ({instr, instr_pc, fetch_fault} !== {mem_word(pc), pc, err_of(pc)}) begin
               n_fail++;
               $display("FAIL rnd_handoff cyc%0d: got %h want %h", cyc,
                        {instr, instr_pc, fetch_fault}, {mem_word(pc), pc, err_of(pc)});
            end
         end
      end
      n_assert++;
      if (handoffs < 100) begin
         n_fail++;
         $display("FAIL rnd_throughput: got %0d hand-offs want at least 100", handoffs);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_redirect_wait();
      test_redirect_same_cycle();
      test_faults();
      test_backpressure();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
